// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver front-end and the command FSM.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic [1:0] CMD_SEND  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Rounded clock divider that produces one oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned tick_rate;
        tick_rate = baud * oversample;
        return (clk_freq + tick_rate / 2) / tick_rate;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte hand-off bus from the UART receiver to the command FSM.
interface uart_rx_frontend_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] o_data;
    logic                      o_push;
    logic                      o_frame_err;
    logic                      o_busy;

    modport master (output o_data, output o_push, output o_frame_err, output o_busy);
    modport slave  (input  o_data, input  o_push, input  o_frame_err, input  o_busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider with enable and synchronous clear; one-cycle tick at the last count.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_tick_c = i_en && !i_clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchroniser, oversampled 3-sample majority voting,
// glitch rejection, framing-error detection and break recovery.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       i_rx,
    uart_rx_frontend_if.master         o_rx_if
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    rx_state_t                 r_state;
    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_rx_prev;
    logic [S_W-1:0]            r_s;
    logic [S_W-1:0]            r_brk;
    logic [BIT_W-1:0]          r_bit;
    logic [1:0]                r_smp;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_push;
    logic                      r_ferr;
    logic                      r_busy;

    logic w_rx_s;
    logic w_tick;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_mid;
    logic w_maj;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s     = r_sync2;
    assign w_tick_en  = (r_state != IDLE);
    assign w_tick_clr = (r_state == IDLE);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk      (in_clk),
        .rst_n    (in_rst),
        .i_en     (w_tick_en),
        .i_clr    (w_tick_clr),
        .o_tick_c (w_tick)
    );

    // Decision point: third of three consecutive samples centred on mid-bit.
    assign w_mid = w_tick && (r_s == S_MID);
    assign w_maj = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx_s) | (r_smp[0] & w_rx_s);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state   <= IDLE;
            r_rx_prev <= 1'b1;
            r_s       <= '0;
            r_brk     <= '0;
            r_bit     <= '0;
            r_smp     <= 2'b11;
            r_shift   <= '0;
            r_data    <= '0;
            r_push    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_push    <= 1'b0;
            r_ferr    <= 1'b0;
            r_rx_prev <= w_rx_s;
            if (w_tick) begin
                r_s   <= (r_s == S_LAST) ? '0 : r_s + S_W'(1);
                r_smp <= {r_smp[0], w_rx_s};
            end
            case (r_state)
                IDLE: begin
                    r_s <= '0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_mid) begin
                        if (!w_maj) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_maj, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge can be caught early.
                    if (w_mid) begin
                        if (w_maj) begin
                            r_data  <= r_shift;
                            r_push  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_brk   <= '0;
                            r_state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Need a full bit time of continuous high before re-arming.
                    if (!w_rx_s) begin
                        r_brk <= '0;
                    end else if (w_tick) begin
                        if (r_brk == S_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_brk <= r_brk + S_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_if.o_data      = r_data;
    assign o_rx_if.o_push      = r_push;
    assign o_rx_if.o_frame_err = r_ferr;
    assign o_rx_if.o_busy      = r_busy;

endmodule
